// File: rtl/alu_pkg.sv
// Shared constants for the arbitrated ALU: opcodes, data width and the
// arbiter state encoding.
package alu_pkg;

   localparam int DATA_W = 8;

   localparam logic [2:0] OP_SUM  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_PROD = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_MOD  = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu.sv
// Combinational unsigned 8-bit ALU; results truncate to the low byte.
// A zero divisor yields 0 here. The arbiter traps those cases and substitutes its own values.
module alu
   import alu_pkg::*;
(
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_SUM:  result = a + b;
         OP_SUB:  result = a - b;
         OP_PROD: result = a * b;
         OP_DIV:  result = (b == '0) ? '0 : a / b;
         OP_MOD:  result = (b == '0) ? '0 : a % b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// single tagged response port and trapping of bad opcodes / zero divisors.
//
//   state | meaning
//   IDLE  | waiting for a request, grant offered combinationally
//   EXEC  | operands held in registers, counting down EXEC_CYCLES
//   RESP  | result held on rsp_* until the consumer takes it
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int EXEC_CYCLES = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [2:0]        req0_op_i,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [2:0]        req1_op_i,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_id_o,
   output logic [DATA_W-1:0] rsp_result_o,
   output logic              rsp_err_o,
   output logic              busy_o
);

   localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

   state_t            state_q, state_d;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic              id_q;
   logic              ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rsp_result_q;
   logic              rsp_err_q;
   logic              rsp_id_q;

   logic              grant_id;
   logic              accept;
   logic [2:0]        op_sel;
   logic [DATA_W-1:0] a_sel, b_sel;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] trap_result;
   logic              trap_err;

   // With both valid the requester that did not win last time is served.
   assign grant_id = (req0_valid_i && req1_valid_i) ? ~ptr_q : req1_valid_i;
   assign accept   = (state_q == IDLE) && (req0_valid_i || req1_valid_i) && !rst_i;

   assign req0_ready_o = accept && !grant_id;
   assign req1_ready_o = accept && grant_id;

   assign op_sel = grant_id ? req1_op_i : req0_op_i;
   assign a_sel  = grant_id ? req1_a_i  : req0_a_i;
   assign b_sel  = grant_id ? req1_b_i  : req0_b_i;

   alu u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result)
   );

   always_comb begin
      trap_err    = 1'b0;
      trap_result = alu_result;
      case (op_q)
         OP_SUM, OP_SUB, OP_PROD: ;
         OP_DIV: begin
            if (b_q == '0) begin
               trap_err    = 1'b1;
               trap_result = '1;
            end
         end
         OP_MOD: begin
            if (b_q == '0) begin
               trap_err    = 1'b1;
               trap_result = a_q;
            end
         end
         default: begin
            trap_err    = 1'b1;
            trap_result = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    if (cnt_q == '0) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         ptr_q        <= 1'b1;
         cnt_q        <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
         rsp_id_q     <= 1'b0;
      end else if (accept) begin
         op_q  <= op_sel;
         a_q   <= a_sel;
         b_q   <= b_sel;
         id_q  <= grant_id;
         ptr_q <= grant_id;
         cnt_q <= CNT_LOAD;
      end else if (state_q == EXEC) begin
         if (cnt_q == '0) begin
            rsp_result_q <= trap_result;
            rsp_err_q    <= trap_err;
            rsp_id_q     <= id_q;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign rsp_valid_o  = (state_q == RESP);
   assign busy_o       = (state_q != IDLE);
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (1 and 4 execute cycles) checked every
// cycle against a transaction-level model, plus directed literal cases.
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      rst, v0, v1, rr, rdy0, rdy1, rv, rid, rerr, busy;
   logic [1:0][2:0] op0, op1;
   logic [1:0][7:0] a0, b0, a1, b1, rres;

   int n_tests = 0;
   int n_fail  = 0;
   int ecyc[2] = '{1, 4};

   // model state: outstanding op, cycles since accept, round-robin pointer
   bit m_busy[2];
   int m_age[2];
   int m_ptr[2];
   int m_id[2], m_res[2], m_err[2];
   bit m_fresh[2];

   int resp_ids[$];
   int resp_cnt[2];

   alu_arbiter #(.EXEC_CYCLES(1)) dut_a (
      .clk_i(clk), .rst_i(rst[0]),
      .req0_valid_i(v0[0]), .req0_ready_o(rdy0[0]), .req0_op_i(op0[0]),
      .req0_a_i(a0[0]), .req0_b_i(b0[0]),
      .req1_valid_i(v1[0]), .req1_ready_o(rdy1[0]), .req1_op_i(op1[0]),
      .req1_a_i(a1[0]), .req1_b_i(b1[0]),
      .rsp_valid_o(rv[0]), .rsp_ready_i(rr[0]), .rsp_id_o(rid[0]),
      .rsp_result_o(rres[0]), .rsp_err_o(rerr[0]), .busy_o(busy[0]));

   alu_arbiter #(.EXEC_CYCLES(4)) dut_b (
      .clk_i(clk), .rst_i(rst[1]),
      .req0_valid_i(v0[1]), .req0_ready_o(rdy0[1]), .req0_op_i(op0[1]),
      .req0_a_i(a0[1]), .req0_b_i(b0[1]),
      .req1_valid_i(v1[1]), .req1_ready_o(rdy1[1]), .req1_op_i(op1[1]),
      .req1_a_i(a1[1]), .req1_b_i(b1[1]),
      .rsp_valid_o(rv[1]), .rsp_ready_i(rr[1]), .rsp_id_o(rid[1]),
      .rsp_result_o(rres[1]), .rsp_err_o(rerr[1]), .busy_o(busy[1]));

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int grant_of(input bit va, input bit vb, input int ptr);
      if (va && vb) return (ptr == 1) ? 0 : 1;
      if (va) return 0;
      if (vb) return 1;
      return -1;
   endfunction

   function automatic void ref_alu(input int op, input int a, input int b,
                                   output int res, output int err);
      err = 0;
      case (op)
         0: res = (a + b) % 256;
         1: res = (a - b + 256) % 256;
         2: res = (a * b) % 256;
         3: if (b == 0) begin res = 255; err = 1; end else res = a / b;
         4: if (b == 0) begin res = a;   err = 1; end else res = a % b;
         default: begin res = 0; err = 1; end
      endcase
   endfunction

   task automatic model_reset(input int i);
      m_busy[i]  = 0;
      m_age[i]   = 0;
      m_ptr[i]   = 1;
      m_id[i]    = 0;
      m_res[i]   = 0;
      m_err[i]   = 0;
      m_fresh[i] = 1;
   endtask

   int mg, mr, me;
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            model_reset(i);
         end else if (!m_busy[i]) begin
            mg = grant_of(v0[i], v1[i], m_ptr[i]);
            if (mg >= 0) begin
               if (mg == 0) ref_alu(int'(op0[i]), int'(a0[i]), int'(b0[i]), mr, me);
               else         ref_alu(int'(op1[i]), int'(a1[i]), int'(b1[i]), mr, me);
               m_busy[i]  = 1;
               m_age[i]   = 1;
               m_ptr[i]   = mg;
               m_id[i]    = mg;
               m_res[i]   = mr;
               m_err[i]   = me;
               m_fresh[i] = 0;
            end
         end else if (m_age[i] >= ecyc[i] + 1) begin
            if (rr[i]) m_busy[i] = 0;
         end else begin
            m_age[i]++;
         end
      end
   end

   int cg;
   bit erv;
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_valid%0d", i), int'(rv[i]), 0);
            chk($sformatf("rst_ready0_%0d", i), int'(rdy0[i]), 0);
            chk($sformatf("rst_ready1_%0d", i), int'(rdy1[i]), 0);
            chk($sformatf("rst_result%0d", i), int'(rres[i]), 0);
            chk($sformatf("rst_id%0d", i), int'(rid[i]), 0);
            chk($sformatf("rst_err%0d", i), int'(rerr[i]), 0);
         end else begin
            cg  = grant_of(v0[i], v1[i], m_ptr[i]);
            erv = m_busy[i] && (m_age[i] >= ecyc[i] + 1);
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_busy[i]));
            chk($sformatf("rsp_valid%0d", i), int'(rv[i]), int'(erv));
            chk($sformatf("ready0_%0d", i), int'(rdy0[i]), int'(!m_busy[i] && cg == 0));
            chk($sformatf("ready1_%0d", i), int'(rdy1[i]), int'(!m_busy[i] && cg == 1));
            if (erv || m_fresh[i]) begin
               chk($sformatf("rsp_id%0d", i), int'(rid[i]), m_id[i]);
               chk($sformatf("rsp_result%0d", i), int'(rres[i]), m_res[i]);
               chk($sformatf("rsp_err%0d", i), int'(rerr[i]), m_err[i]);
            end
            if (rv[i] && rr[i]) begin
               resp_cnt[i]++;
               if (i == 0) resp_ids.push_back(int'(rid[0]));
            end
         end
      end
   end

   task automatic idle_inputs(input int i);
      v0[i] = 0; v1[i] = 0; rr[i] = 1;
      op0[i] = '0; op1[i] = '0;
      a0[i] = '0; b0[i] = '0; a1[i] = '0; b1[i] = '0;
   endtask

   task automatic apply_reset(input int i);
      @(negedge clk); #1;
      rst[i] = 1;
      model_reset(i);
      repeat (2) @(negedge clk);
      #1 rst[i] = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Issue one op on the given port and check latency and literal result.
   task automatic run_op(input int i, input int port, input int op, input int a,
                         input int b, input int exp_res, input int exp_err,
                         input string name);
      int k, n;
      @(negedge clk); #1;
      rr[i] = 1;
      if (port == 0) begin
         v0[i] = 1; op0[i] = 3'(op); a0[i] = 8'(a); b0[i] = 8'(b);
      end else begin
         v1[i] = 1; op1[i] = 3'(op); a1[i] = 8'(a); b1[i] = 8'(b);
      end
      #1;
      k = 0;
      while (!((port == 0) ? rdy0[i] : rdy1[i]) && k < 20) begin
         @(negedge clk); #2;
         k++;
      end
      if (k >= 20) begin
         chk({name, "_accept_timeout"}, k, 0);
         v0[i] = 0; v1[i] = 0;
         return;
      end
      @(posedge clk);
      @(negedge clk); #1;
      v0[i] = 0; v1[i] = 0;
      n = 1;
      while (!rv[i] && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk({name, "_latency"}, n, ecyc[i] + 1);
      chk({name, "_result"}, int'(rres[i]), exp_res);
      chk({name, "_err"}, int'(rerr[i]), exp_err);
      chk({name, "_id"}, int'(rid[i]), port);
      @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap, k, cnt_b;
      for (int i = 0; i < 2; i++) begin
         idle_inputs(i);
         resp_cnt[i] = 0;
      end
      rst = 2'b11;
      model_reset(0);
      model_reset(1);
      wait_cycles(3);
      rst = 2'b00;
      wait_cycles(1);
      chk("reset_busy", int'(busy[0]), 0);
      chk("reset_valid", int'(rv[0]), 0);
      v0[0] = 1; #1;
      chk("reset_first_ready0", int'(rdy0[0]), 1);
      v0[0] = 0;

      run_op(0, 0, 0, 200, 100, 8'h2C, 0, "sum");
      run_op(0, 0, 2, 20, 20, 8'h90, 0, "prod");
      run_op(0, 0, 1, 5, 10, 8'hFB, 0, "sub_wrap");
      run_op(0, 1, 3, 7, 0, 8'hFF, 1, "div0");
      run_op(0, 0, 4, 7, 0, 8'h07, 1, "mod0");
      run_op(0, 1, 7, 9, 3, 8'h00, 1, "badop7");
      run_op(0, 0, 5, 1, 1, 8'h00, 1, "badop5");
      run_op(0, 0, 3, 7, 2, 8'h03, 0, "div");
      run_op(1, 1, 4, 200, 7, 8'h04, 0, "mod_b");
      run_op(1, 0, 2, 255, 255, 8'h01, 0, "prod_b");

      // alternation with both requesters always valid
      apply_reset(0);
      resp_ids.delete();
      @(negedge clk); #1;
      v0[0] = 1; v1[0] = 1; rr[0] = 1;
      op0[0] = 3'd0; a0[0] = 8'd1; b0[0] = 8'd2;
      op1[0] = 3'd1; a1[0] = 8'd9; b1[0] = 8'd4;
      wait_cycles(16);
      v0[0] = 0; v1[0] = 0;
      wait_cycles(6);
      chk("alt_count_ge4", int'(resp_ids.size() >= 4), 1);
      if (resp_ids.size() >= 4) begin
         chk("alt_id0", resp_ids[0], 0);
         chk("alt_id1", resp_ids[1], 1);
         chk("alt_id2", resp_ids[2], 0);
         chk("alt_id3", resp_ids[3], 1);
      end

      // backpressure
      rr[0] = 0;
      v0[0] = 1; op0[0] = 3'd0; a0[0] = 8'd3; b0[0] = 8'd4;
      k = 0;
      while (!rv[0] && k < 20) begin
         wait_cycles(1);
         k++;
      end
      chk("bp_reached_resp", int'(rv[0]), 1);
      v1[0] = 1;
      snap = int'(rres[0]);
      for (int c = 0; c < 5; c++) begin
         wait_cycles(1);
         chk("bp_valid", int'(rv[0]), 1);
         chk("bp_result", int'(rres[0]), 8'd7);
         chk("bp_result_stable", int'(rres[0]), snap);
         chk("bp_ready0", int'(rdy0[0]), 0);
         chk("bp_ready1", int'(rdy1[0]), 0);
         chk("bp_busy", int'(busy[0]), 1);
      end
      rr[0] = 1;
      wait_cycles(1);
      chk("bp_release_idle", int'(busy[0]), 0);
      chk("bp_release_valid", int'(rv[0]), 0);
      v0[0] = 0; v1[0] = 0;
      wait_cycles(8);

      // reset during EXEC on the 4-cycle instance
      apply_reset(1);
      v0[1] = 1; op0[1] = 3'd0; a0[1] = 8'd10; b0[1] = 8'd20;
      #1;
      chk("rexec_ready0", int'(rdy0[1]), 1);
      @(posedge clk);
      @(negedge clk); #1;
      v0[1] = 0;
      wait_cycles(1);
      chk("rexec_in_exec", int'(busy[1]), 1);
      cnt_b = resp_cnt[1];
      rst[1] = 1;
      model_reset(1);
      #1;
      chk("rexec_busy_now", int'(busy[1]), 0);
      chk("rexec_valid_now", int'(rv[1]), 0);
      wait_cycles(1);
      rst[1] = 0;
      v0[1] = 1; v1[1] = 1;
      #1;
      chk("rexec_next_ready0", int'(rdy0[1]), 1);
      chk("rexec_next_ready1", int'(rdy1[1]), 0);
      @(posedge clk);
      @(negedge clk); #1;
      v0[1] = 0; v1[1] = 0;
      wait_cycles(10);
      chk("rexec_one_response", resp_cnt[1], cnt_b + 1);

      // randomized traffic on both instances
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(199) == 0) begin
               rst[i] = 1;
               model_reset(i);
            end else begin
               rst[i] = 0;
            end
            v0[i]  = ($urandom_range(2) != 0);
            v1[i]  = ($urandom_range(2) != 0);
            rr[i]  = ($urandom_range(3) != 0);
            op0[i] = 3'($urandom_range(7));
            op1[i] = 3'($urandom_range(7));
            a0[i]  = 8'($urandom);
            a1[i]  = 8'($urandom);
            b0[i]  = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom);
            b1[i]  = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom);
         end
      end
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 0;
         idle_inputs(i);
      end
      wait_cycles(12);
      chk("final_idle_a", int'(busy[0]), 0);
      chk("final_idle_b", int'(busy[1]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
